conv1d_mac_ctrl: RTL and testbench

CONV1D_MAC_CTRL -- requirements
Module: conv1d_mac_ctrl

---
 rtl/conv1d_mac_ctrl_pkg.sv | 25 ++
 rtl/conv1d_mac_ctrl_if.sv | 40 ++++
 rtl/conv1d_addr_gen.sv | 31 +++
 rtl/conv1d_mac_ctrl.sv | 126 ++++++++++++
 tb/tb_conv1d_mac_ctrl.sv | 190 +++++++++++++++++++
 5 files changed

// File: rtl/conv1d_mac_ctrl_pkg.sv
// Shared definitions for the conv1d MAC controller: data widths, kernel limits, FSM encoding.
// Data width comes from the WIDTH_DATA macro (defaults to 16 when not supplied by the build).
`ifndef WIDTH_DATA
`define WIDTH_DATA 16
`endif

package conv1d_mac_ctrl_pkg;

  localparam int DATA_W     = `WIDTH_DATA;
  localparam int PSUM_W     = 2 * DATA_W;

  // Legal KERNEL_SIZE range; a 4-bit tap counter covers the upper limit plus one.
  localparam int KERNEL_MIN = 2;
  localparam int KERNEL_MAX = 15;
  localparam int TAP_W      = 4;

  typedef enum logic [2:0] {
    IDLE  = 3'd0,
    FETCH = 3'd1,
    DRAIN = 3'd2,
    OUT   = 3'd3,
    DONE  = 3'd4
  } state_t;

endpackage

// File: rtl/conv1d_mac_ctrl_if.sv
// Bundle of run control, memory read, external MAC and result stream signals.
// master = the controller, slave = memories/MAC/stream consumer around it.
interface conv1d_mac_ctrl_if #(
  parameter int LEN_W = 8
);
  import conv1d_mac_ctrl_pkg::*;

  logic                     start;
  logic [LEN_W-1:0]         cfg_len;
  logic                     busy;
  logic                     done;

  logic                     rd_en;
  logic [TAP_W-1:0]         w_addr;
  logic [LEN_W-1:0]         f_addr;
  logic signed [DATA_W-1:0] w_rdata;
  logic signed [DATA_W-1:0] f_rdata;

  logic signed [DATA_W-1:0] mac_weight;
  logic signed [DATA_W-1:0] mac_feature;
  logic signed [PSUM_W-1:0] mac_psum_in;
  logic signed [PSUM_W-1:0] mac_psum_out;

  logic                     out_valid;
  logic                     out_ready;
  logic signed [PSUM_W-1:0] out_data;

  modport master (
    input  start, cfg_len, w_rdata, f_rdata, mac_psum_out, out_ready,
    output busy, done, rd_en, w_addr, f_addr,
           mac_weight, mac_feature, mac_psum_in, out_valid, out_data
  );

  modport slave (
    output start, cfg_len, w_rdata, f_rdata, mac_psum_out, out_ready,
    input  busy, done, rd_en, w_addr, f_addr,
           mac_weight, mac_feature, mac_psum_in, out_valid, out_data
  );

endinterface

// File: rtl/conv1d_addr_gen.sv
// Output-index / tap counters for the conv1d controller and the feature address o_idx + tap.
module conv1d_addr_gen
  import conv1d_mac_ctrl_pkg::*;
#(
  parameter int LEN_W = 8
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             clear,
  input  logic             step,
  input  logic             advance,
  output logic [TAP_W-1:0] tap,
  output logic [LEN_W-1:0] o_idx,
  output logic [LEN_W-1:0] f_addr
);

  always_ff @(posedge clk) begin
    if (!rst_n || clear) begin
      tap   <= '0;
      o_idx <= '0;
    end else if (advance) begin
      tap   <= '0;
      o_idx <= o_idx + 1'b1;
    end else if (step) begin
      tap   <= tap + 1'b1;
    end
  end

  assign f_addr = o_idx + LEN_W'(tap);

endmodule

// File: rtl/conv1d_mac_ctrl.sv
// Sequencer for a 1-D convolution built around an external combinational MAC.
// Optional macro CONV1D_RELU_EN clamps negative results to zero on out_data.
module conv1d_mac_ctrl
  import conv1d_mac_ctrl_pkg::*;
#(
  parameter int KERNEL_SIZE = 3,
  parameter int LEN_W       = 8
) (
  input  logic              clk,
  input  logic              rst_n,
  conv1d_mac_ctrl_if.master bus
);

  localparam logic [TAP_W-1:0] TAP_LAST = TAP_W'(KERNEL_SIZE - 1);
  localparam logic [LEN_W-1:0] K_LEN    = LEN_W'(KERNEL_SIZE);

  function automatic logic signed [PSUM_W-1:0] shape_out(input logic signed [PSUM_W-1:0] v);
`ifdef CONV1D_RELU_EN
    shape_out = v[PSUM_W-1] ? '0 : v;
`else
    shape_out = v;
`endif
  endfunction

  state_t                   state, state_nxt;
  logic [LEN_W-1:0]         len_q;
  logic signed [PSUM_W-1:0] acc;
  logic                     acc_en_p1;
  logic [TAP_W-1:0]         tap;
  logic [LEN_W-1:0]         o_idx;
  logic [LEN_W-1:0]         f_addr_sum;

  logic                     start_ok, start_run, handshake, tap_last, last_out;
  logic                     busy, done, rd_en, out_valid;
  logic [TAP_W-1:0]         w_addr;
  logic [LEN_W-1:0]         f_addr;
  logic signed [PSUM_W-1:0] out_data;

  assign start_ok  = (state == IDLE) && bus.start;
  assign start_run = start_ok && (bus.cfg_len >= K_LEN);
  assign handshake = (state == OUT) && bus.out_ready;
  assign tap_last  = (tap == TAP_LAST);
  assign last_out  = (o_idx == len_q - K_LEN);

  conv1d_addr_gen #(
    .LEN_W (LEN_W)
  ) u_addr_gen (
    .clk     (clk),
    .rst_n   (rst_n),
    .clear   (start_run),
    .step    (state == FETCH),
    .advance (handshake),
    .tap     (tap),
    .o_idx   (o_idx),
    .f_addr  (f_addr_sum)
  );

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state <= IDLE;
      len_q <= '0;
    end else begin
      state <= state_nxt;
      if (start_run) len_q <= bus.cfg_len;
    end
  end

  // Stage p1: read data arrives one cycle after a FETCH, MAC result folds into acc.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      acc_en_p1 <= 1'b0;
      acc       <= '0;
    end else begin
      acc_en_p1 <= (state == FETCH);
      if (start_run || handshake) acc <= '0;
      else if (acc_en_p1)         acc <= bus.mac_psum_out;
    end
  end

  always_comb begin
    state_nxt = state;
    busy      = (state != IDLE);
    done      = 1'b0;
    rd_en     = 1'b0;
    w_addr    = '0;
    f_addr    = '0;
    out_valid = 1'b0;
    out_data  = '0;
    case (state)
      IDLE: begin
        if (start_ok) state_nxt = start_run ? FETCH : DONE;
      end
      FETCH: begin
        rd_en  = 1'b1;
        w_addr = tap;
        f_addr = f_addr_sum;
        if (tap_last) state_nxt = DRAIN;
      end
      DRAIN: begin
        state_nxt = OUT;
      end
      OUT: begin
        out_valid = 1'b1;
        out_data  = shape_out(acc);
        if (bus.out_ready) state_nxt = last_out ? DONE : FETCH;
      end
      DONE: begin
        done      = 1'b1;
        state_nxt = IDLE;
      end
      default: state_nxt = IDLE;
    endcase
  end

  assign bus.busy        = busy;
  assign bus.done        = done;
  assign bus.rd_en       = rd_en;
  assign bus.w_addr      = w_addr;
  assign bus.f_addr      = f_addr;
  assign bus.out_valid   = out_valid;
  assign bus.out_data    = out_data;
  assign bus.mac_weight  = acc_en_p1 ? bus.w_rdata : '0;
  assign bus.mac_feature = acc_en_p1 ? bus.f_rdata : '0;
  assign bus.mac_psum_in = acc_en_p1 ? acc : '0;

endmodule

// File: tb/tb_conv1d_mac_ctrl.sv
// Self-checking bench for conv1d_mac_ctrl: memory + MAC models around the DUT, sum-of-products reference.
`timescale 1ns/1ps
module tb_conv1d_mac_ctrl;
  import conv1d_mac_ctrl_pkg::*;

  localparam int K     = 3;
  localparam int LEN_W = 8;

  logic clk = 1'b0;
  logic rst_n = 1'b0;
  always #5 clk = ~clk;

  conv1d_mac_ctrl_if #(.LEN_W(LEN_W)) bus ();

  conv1d_mac_ctrl #(
    .KERNEL_SIZE (K),
    .LEN_W       (LEN_W)
  ) dut (
    .clk   (clk),
    .rst_n (rst_n),
    .bus   (bus)
  );

  logic signed [DATA_W-1:0] w_mem [16];
  logic signed [DATA_W-1:0] f_mem [256];
  logic signed [PSUM_W-1:0] exp_q [$];

  // Synchronous memories with one-cycle read latency, and the combinational MAC.
  always @(posedge clk) begin
    if (bus.rd_en) begin
      bus.w_rdata <= w_mem[bus.w_addr];
      bus.f_rdata <= f_mem[bus.f_addr];
    end
  end
  assign bus.mac_psum_out = bus.mac_psum_in + bus.mac_weight * bus.mac_feature;

  int tests = 0;
  int fails = 0;

  task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    tests++;
    assert (obs === exp) else begin
      fails++;
      $error("FAIL %s: observed %0d required %0d", tag, $signed(obs), $signed(exp));
    end
  endtask

  // Reference: out[o] = sum_t w[t]*f[o+t], wrapped to the psum width, optionally ReLU'd.
  task automatic build_expected(input int len);
    exp_q.delete();
    for (int o = 0; o + K <= len; o++) begin
      logic signed [PSUM_W-1:0] s;
      s = '0;
      for (int t = 0; t < K; t++) begin
        longint p;
        p = longint'(w_mem[t]) * longint'(f_mem[o + t]);
        s = s + PSUM_W'(p);
      end
`ifdef CONV1D_RELU_EN
      if (s < 0) s = '0;
`endif
      exp_q.push_back(s);
    end
  endtask

  task automatic load_basic();
    for (int i = 0; i < 16; i++)  w_mem[i] = '0;
    for (int i = 0; i < 256; i++) f_mem[i] = DATA_W'(i + 1);
    w_mem[0] = 1; w_mem[1] = 2; w_mem[2] = 3;
  endtask

  task automatic check_all_zero(input string name);
    check({name, " busy"},      bus.busy, 0);
    check({name, " done"},      bus.done, 0);
    check({name, " out_valid"}, bus.out_valid, 0);
    check({name, " rd_en"},     bus.rd_en, 0);
    check({name, " out_data"},  bus.out_data, 0);
    check({name, " mac_in"},    {bus.mac_weight, bus.mac_feature, bus.mac_psum_in} != 0, 0);
  endtask

  // One run: start with len, optional initial stall, random ready, mid-run reset, or ignored restart.
  task automatic run_case(input string name, input int len, input int stall, input bit rnd_ready,
                          input int rst_after, input bit restart);
    int n_out, got, reads, done_cyc, first_vld, last_hs, stall_left, cyc;
    bit stable_ok, mac_ok, busy_ok, prev_rd, prev_hold, aborted;
    logic signed [PSUM_W-1:0] held;
    build_expected(len);
    n_out = exp_q.size();
    got = 0; reads = 0; done_cyc = -1; first_vld = -1; last_hs = -1; stall_left = stall;
    stable_ok = 1; mac_ok = 1; busy_ok = 1; prev_rd = 0; prev_hold = 0; aborted = 0; held = '0;

    @(negedge clk);
    bus.start = 1'b1; bus.cfg_len = LEN_W'(len); bus.out_ready = 1'b1;
    @(negedge clk);
    bus.start = 1'b0; bus.cfg_len = LEN_W'(len + 37);
    for (cyc = 1; cyc <= 800 && done_cyc < 0 && !aborted; cyc++) begin
      if (!prev_rd && (bus.mac_weight != 0 || bus.mac_feature != 0 || bus.mac_psum_in != 0)) mac_ok = 0;
      prev_rd = bus.rd_en;
      if (bus.rd_en) reads++;
      if (bus.rd_en && bus.out_valid) stable_ok = 0;
      if (!bus.busy) busy_ok = 0;
      bus.start = (restart && cyc == 2);
      if (restart && cyc == 2) bus.cfg_len = LEN_W'(len + 4);
      if (bus.out_valid) begin
        if (first_vld < 0) first_vld = cyc;
        if (prev_hold && bus.out_data !== held) stable_ok = 0;
        if (stall_left > 0) begin
          bus.out_ready = 1'b0;
          stall_left--;
        end else begin
          bus.out_ready = rnd_ready ? 1'($urandom_range(0, 1)) : 1'b1;
        end
        if (bus.out_ready) begin
          if (got < n_out) check($sformatf("%s out[%0d]", name, got), bus.out_data, exp_q[got]);
          got++;
          last_hs = cyc;
          prev_hold = 0;
        end else begin
          held = bus.out_data;
          prev_hold = 1;
        end
      end else begin
        prev_hold = 0;
        bus.out_ready = rnd_ready ? 1'($urandom_range(0, 1)) : 1'b1;
      end
      if (bus.done) done_cyc = cyc;
      if (rst_after >= 0 && got == rst_after && bus.rd_en) aborted = 1;
      if (!aborted) @(negedge clk);
    end
    bus.start = 1'b0;

    if (aborted) begin
      rst_n = 1'b0;
      @(negedge clk);
      check_all_zero({name, " after rst"});
      check({name, " addr after rst"}, {bus.w_addr, bus.f_addr}, 0);
      rst_n = 1'b1;
      done_cyc = 0;
      for (int i = 0; i < 4; i++) begin
        @(negedge clk);
        if (bus.done || bus.busy) done_cyc = 1;
      end
      check({name, " quiet after rst"}, done_cyc, 0);
    end else begin
      check({name, " count"},      got, n_out);
      check({name, " reads"},      reads, K * n_out);
      check({name, " first vld"},  first_vld, (n_out > 0) ? K + 2 : -1);
      check({name, " done cyc"},   done_cyc, (n_out > 0) ? last_hs + 1 : 1);
      check({name, " stable"},     stable_ok, 1);
      check({name, " mac idle 0"}, mac_ok, 1);
      check({name, " busy run"},   busy_ok, 1);
      check({name, " busy after"}, bus.busy, 0);
      check({name, " done once"},  bus.done, 0);
    end
  endtask

  initial begin
    bus.start = 1'b0;
    bus.cfg_len = '0;
    bus.out_ready = 1'b0;
    load_basic();
    rst_n = 1'b0;
    repeat (3) @(negedge clk);
    check_all_zero("reset");
    rst_n = 1'b1;

    run_case("basic", 5, 0, 0, -1, 0);
    run_case("stall", 5, 4, 0, -1, 0);
    run_case("short", 2, 0, 0, -1, 0);

    for (int i = 0; i < 16; i++) w_mem[i] = -1;
    for (int i = 0; i < 256; i++) f_mem[i] = 1;
    run_case("neg", 4, 0, 0, -1, 0);

    load_basic();
    run_case("midrst", 5, 0, 0, 1, 0);
    run_case("rerun", 5, 0, 0, -1, 0);
    run_case("restart", 6, 0, 0, -1, 1);

    for (int r = 0; r < 8; r++) begin
      for (int i = 0; i < 16; i++)  w_mem[i] = DATA_W'($urandom);
      for (int i = 0; i < 256; i++) f_mem[i] = DATA_W'($urandom);
      run_case($sformatf("rand%0d", r), $urandom_range(0, 20), $urandom_range(0, 3), 1, -1, 0);
    end

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
